// File: rtl/hazard_stall_controller.sv
// Load-use and MULT/DIV (HI/LO) hazard stall controller for the ID stage.
// Optional macro STALL_STATS_EN enables the saturating STALL_COUNT statistic.
module hazard_stall_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16,
    parameter int CNT_W       = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_RS,
    input  logic [4:0]  ID_RT,
    input  logic        ID_USES_RS,
    input  logic        ID_USES_RT,
    input  logic        ID_MD_START,
    input  logic        ID_MD_IS_DIV,
    input  logic        ID_USES_HILO,
    input  logic        EX_LOAD_INSTR,
    input  logic        EX_RF_ENABLE,
    input  logic [4:0]  EX_REGEX,
    output logic        PC_LE,
    output logic        IF_ID_LE,
    output logic        ID_EX_NOP,
    output logic        MD_BUSY,
    output logic        MD_DONE,
    output logic [1:0]  STATE,
    output logic [15:0] STALL_COUNT
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             md_done;
    logic             lu_hazard, md_hazard, stall;

    always_comb begin
        lu_hazard = EX_LOAD_INSTR & EX_RF_ENABLE & (EX_REGEX != 5'd0) &
                    ((ID_USES_RS & (ID_RS == EX_REGEX)) |
                     (ID_USES_RT & (ID_RT == EX_REGEX)));
        md_hazard = busy_q & (ID_USES_HILO | ID_MD_START);
        stall     = lu_hazard | md_hazard;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        md_done = 1'b0;
        case (state_q)
            RUN: begin
                if (lu_hazard) begin
                    state_d = LU_STALL;
                end else if (ID_MD_START) begin
                    state_d = MD_WAIT;
                    busy_d  = 1'b1;
                    cnt_d   = ID_MD_IS_DIV ? DIV_LOAD : MULT_LOAD;
                end
            end
            LU_STALL: begin
                // The bubble now sits in EX, so a held MULT/DIV may start here.
                state_d = RUN;
                if (ID_MD_START && !lu_hazard) begin
                    state_d = MD_WAIT;
                    busy_d  = 1'b1;
                    cnt_d   = ID_MD_IS_DIV ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_WAIT: begin
                if (cnt_q == '0) begin
                    md_done = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Reset forces a bubble and freezes fetch, and aborts any pending MD_DONE.
    assign PC_LE     = ~Reset & ~stall;
    assign IF_ID_LE  = ~Reset & ~stall;
    assign ID_EX_NOP = Reset | stall;
    assign MD_BUSY   = busy_q;
    assign MD_DONE   = md_done & ~Reset;
    assign STATE     = state_q;

`ifdef STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_COUNT = stall_cnt_q;
`else
    assign STALL_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: load-use vector table plus
// hand-written MULT/DIV, reset-abort and stall-statistics sequences.
module tb_hazard_stall_controller;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ID_RS, ID_RT, EX_REGEX;
    logic        ID_USES_RS, ID_USES_RT, ID_MD_START, ID_MD_IS_DIV, ID_USES_HILO;
    logic        EX_LOAD_INSTR, EX_RF_ENABLE;
    logic        PC_LE, IF_ID_LE, ID_EX_NOP, MD_BUSY, MD_DONE;
    logic [1:0]  STATE;
    logic [15:0] STALL_COUNT;

    int tests_run    = 0;
    int tests_failed = 0;

    hazard_stall_controller #(.MULT_CYCLES(4), .DIV_CYCLES(16), .CNT_W(5)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ID_RS        (ID_RS),
        .ID_RT        (ID_RT),
        .ID_USES_RS   (ID_USES_RS),
        .ID_USES_RT   (ID_USES_RT),
        .ID_MD_START  (ID_MD_START),
        .ID_MD_IS_DIV (ID_MD_IS_DIV),
        .ID_USES_HILO (ID_USES_HILO),
        .EX_LOAD_INSTR(EX_LOAD_INSTR),
        .EX_RF_ENABLE (EX_RF_ENABLE),
        .EX_REGEX     (EX_REGEX),
        .PC_LE        (PC_LE),
        .IF_ID_LE     (IF_ID_LE),
        .ID_EX_NOP    (ID_EX_NOP),
        .MD_BUSY      (MD_BUSY),
        .MD_DONE      (MD_DONE),
        .STATE        (STATE),
        .STALL_COUNT  (STALL_COUNT)
    );

    // Clock / watchdog
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       ex_load;
        logic       ex_rf;
        logic [4:0] ex_regex;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       exp_stall;
    } lu_vec_t;

    lu_vec_t vecs[9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_RS = 5'd0; ID_RT = 5'd0; EX_REGEX = 5'd0;
        ID_USES_RS = 1'b0; ID_USES_RT = 1'b0;
        ID_MD_START = 1'b0; ID_MD_IS_DIV = 1'b0; ID_USES_HILO = 1'b0;
        EX_LOAD_INSTR = 1'b0; EX_RF_ENABLE = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        EX_LOAD_INSTR = 1'b1; EX_RF_ENABLE = 1'b1; EX_REGEX = r;
        ID_RS = r; ID_USES_RS = 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        clear_inputs();
    endtask

    // One MULT start followed by a HI/LO consumer held for the four busy cycles,
    // with a concurrent load-use hazard on the second busy cycle.
    task automatic mult_seq();
        ID_MD_START = 1'b1; ID_MD_IS_DIV = 1'b0;
        #1;
        check("mult_start_no_stall", {15'd0, PC_LE}, 16'd1);
        check("mult_start_busy0", {15'd0, MD_BUSY}, 16'd0);
        step();
        ID_MD_START = 1'b0; ID_USES_HILO = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) set_lu(5'd6);
            else begin EX_LOAD_INSTR = 1'b0; ID_USES_RS = 1'b0; end
            #1;
            check($sformatf("mult_busy_c%0d", i), {15'd0, MD_BUSY}, 16'd1);
            check($sformatf("mult_nop_c%0d", i), {15'd0, ID_EX_NOP}, 16'd1);
            check($sformatf("mult_done_c%0d", i), {15'd0, MD_DONE}, {15'd0, (i == 4)});
            check($sformatf("mult_state_c%0d", i), {14'd0, STATE}, 16'd2);
            step();
        end
        #1;
        check("mult_after_busy", {15'd0, MD_BUSY}, 16'd0);
        check("mult_after_pcle", {15'd0, PC_LE}, 16'd1);
        check("mult_after_state", {14'd0, STATE}, 16'd0);
        check("mult_after_done", {15'd0, MD_DONE}, 16'd0);
        clear_inputs();
        step();
    endtask

    logic [15:0] exp_stats;
    logic        done_seen;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 5'd9,  5'd9,  5'd2,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 5'd4,  5'd5,  5'd6,  1'b1, 1'b1, 1'b0};

        // Reset dominates: hazard and MD start presented during reset
        clear_inputs();
        Reset = 1'b1;
        set_lu(5'd3);
        ID_MD_START = 1'b1;
        step();
        check("rst_pcle", {15'd0, PC_LE}, 16'd0);
        check("rst_ifidle", {15'd0, IF_ID_LE}, 16'd0);
        check("rst_nop", {15'd0, ID_EX_NOP}, 16'd1);
        check("rst_done", {15'd0, MD_DONE}, 16'd0);
        step();
        Reset = 1'b0;
        clear_inputs();
        #1;
        check("rst_state", {14'd0, STATE}, 16'd0);
        check("rst_busy", {15'd0, MD_BUSY}, 16'd0);
        check("rst_stats", STALL_COUNT, 16'd0);
        check("rst_released_pcle", {15'd0, PC_LE}, 16'd1);
        step();

        // Load-use vector table
        for (int v = 0; v < 9; v++) begin
            EX_LOAD_INSTR = vecs[v].ex_load;
            EX_RF_ENABLE  = vecs[v].ex_rf;
            EX_REGEX      = vecs[v].ex_regex;
            ID_RS         = vecs[v].id_rs;
            ID_RT         = vecs[v].id_rt;
            ID_USES_RS    = vecs[v].uses_rs;
            ID_USES_RT    = vecs[v].uses_rt;
            #1;
            check($sformatf("v%0d_pcle", v), {15'd0, PC_LE}, {15'd0, ~vecs[v].exp_stall});
            check($sformatf("v%0d_ifidle", v), {15'd0, IF_ID_LE}, {15'd0, ~vecs[v].exp_stall});
            check($sformatf("v%0d_nop", v), {15'd0, ID_EX_NOP}, {15'd0, vecs[v].exp_stall});
            step();
            clear_inputs();
            #1;
            check($sformatf("v%0d_state1", v), {14'd0, STATE}, {15'd0, vecs[v].exp_stall});
            check($sformatf("v%0d_pcle1", v), {15'd0, PC_LE}, 16'd1);
            step();
            check($sformatf("v%0d_state2", v), {14'd0, STATE}, 16'd0);
        end

        mult_seq();

        // DIV with independent instructions, second DIV arriving in cycle 10
        ID_MD_START = 1'b1; ID_MD_IS_DIV = 1'b1;
        step();
        ID_MD_START = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 10) begin ID_MD_START = 1'b1; ID_MD_IS_DIV = 1'b1; end
            #1;
            check($sformatf("div_busy_c%0d", i), {15'd0, MD_BUSY}, 16'd1);
            check($sformatf("div_done_c%0d", i), {15'd0, MD_DONE}, {15'd0, (i == 16)});
            check($sformatf("div_nop_c%0d", i), {15'd0, ID_EX_NOP}, {15'd0, (i >= 10)});
            step();
        end
        #1;
        check("div2_accept_busy", {15'd0, MD_BUSY}, 16'd0);
        check("div2_accept_pcle", {15'd0, PC_LE}, 16'd1);
        step();
        clear_inputs();
        for (int i = 1; i <= 16; i++) begin
            #1;
            check($sformatf("div2_busy_c%0d", i), {15'd0, MD_BUSY}, 16'd1);
            check($sformatf("div2_done_c%0d", i), {15'd0, MD_DONE}, {15'd0, (i == 16)});
            step();
        end
        #1;
        check("div2_after_busy", {15'd0, MD_BUSY}, 16'd0);
        check("div2_after_state", {14'd0, STATE}, 16'd0);

        // Reset in cycle 3 of a DIV aborts it without MD_DONE
        step();
        ID_MD_START = 1'b1; ID_MD_IS_DIV = 1'b1;
        step();
        ID_MD_START = 1'b0;
        step();
        step();
        Reset = 1'b1;
        #1;
        check("abort_rst_pcle", {15'd0, PC_LE}, 16'd0);
        check("abort_rst_nop", {15'd0, ID_EX_NOP}, 16'd1);
        step();
        Reset = 1'b0;
        #1;
        check("abort_busy", {15'd0, MD_BUSY}, 16'd0);
        check("abort_state", {14'd0, STATE}, 16'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (MD_DONE) done_seen = 1'b1;
            step();
        end
        check("abort_no_done", {15'd0, done_seen}, 16'd0);

        // Stall statistic: three load-use stalls plus a four-cycle MULT stall
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_lu(5'(i + 1));
            step();
            clear_inputs();
            step();
        end
        mult_seq();
`ifdef STALL_STATS_EN
        exp_stats = 16'd7;
`else
        exp_stats = 16'd0;
`endif
        check("stats_seven", STALL_COUNT, exp_stats);
`ifdef STALL_STATS_EN
        set_lu(5'd12);
        for (int i = 0; i < 70000; i++) step();
        check("stats_saturate", STALL_COUNT, 16'hFFFF);
        clear_inputs();
        do_reset();
        #1;
        check("stats_cleared", STALL_COUNT, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
